// File: rtl/variable_table_readout_pkg.sv
// Shared types and default widths for the variable table readout path.
// The state encoding is shared so the FSM and any debug taps agree on values.
package variable_table_readout_pkg;

    localparam int VAR_AW   = 11;
    localparam int TID_W    = 4;
    localparam int TABLE_AW = TID_W + VAR_AW;
    localparam int WCNT_W   = VAR_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/variable_table_readout_bit_packer.sv
// Collects table read bits LSB-first into one output word.
// The write position advances per captured bit and resets on clear.
module variable_table_readout_bit_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic                  i_bit,
    output logic [DATA_WIDTH-1:0] o_word
);

    localparam int POS_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_word;
    logic [POS_W-1:0]      r_pos;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_word <= '0;
            r_pos  <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_pos  <= '0;
        end else if (i_shift) begin
            r_word[r_pos] <= i_bit;
            r_pos         <= r_pos + POS_W'(1);
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/variable_table_readout.sv
// Walks one thread's variable region through the table read port and
// streams the assignment bits, packed LSB-first, to the host.
module variable_table_readout
    import variable_table_readout_pkg::*;
#(
    parameter int VARIABLE_ADDRESS_WIDTH = VAR_AW,
    parameter int THREAD_ID_WIDTH        = TID_W,
    parameter int DATA_WIDTH             = 32
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        start_i,
    input  logic [THREAD_ID_WIDTH-1:0]                  thread_id_i,
    input  logic [VARIABLE_ADDRESS_WIDTH:0]             num_vars_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        rd_en_o,
    output logic [THREAD_ID_WIDTH+VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_o,
    input  logic                                        rd_data_i,
    output logic [DATA_WIDTH-1:0]                       m_data_o,
    output logic                                        m_valid_o,
    output logic                                        m_last_o,
    input  logic                                        m_ready_i
);

    localparam int ADDR_W = THREAD_ID_WIDTH + VARIABLE_ADDRESS_WIDTH;
    localparam int CNT_W  = VARIABLE_ADDRESS_WIDTH + 1;
    localparam int POS_W  = $clog2(DATA_WIDTH);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATA_WIDTH - 1);

    state_t                            r_state;
    logic [THREAD_ID_WIDTH-1:0]        r_tid;
    logic [CNT_W-1:0]                  r_num;
    logic [VARIABLE_ADDRESS_WIDTH-1:0] r_var_idx;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_rd_en;
    logic [ADDR_W-1:0]                 r_rd_addr;
    logic                              r_cap;
    logic                              r_m_valid;
    logic                              r_m_last;
    logic                              r_last_seen;

    logic                              w_start;
    logic                              w_handoff;
    logic                              w_is_last;
    logic                              w_word_end;
    logic [VARIABLE_ADDRESS_WIDTH-1:0] w_var_next;
    logic [DATA_WIDTH-1:0]             w_word;

    assign w_start    = (r_state == S_IDLE) && start_i;
    assign w_handoff  = r_m_valid && m_ready_i;
    assign w_is_last  = {1'b0, r_var_idx} == (r_num - CNT_W'(1));
    assign w_word_end = r_var_idx[POS_W-1:0] == POS_LAST;
    assign w_var_next = r_var_idx + VARIABLE_ADDRESS_WIDTH'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_tid       <= '0;
            r_num       <= '0;
            r_var_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_cap       <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_last_seen <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Read data lands one cycle after the enable.
            r_cap  <= r_rd_en;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_tid       <= thread_id_i;
                        r_num       <= num_vars_i;
                        r_var_idx   <= '0;
                        r_last_seen <= 1'b0;
                        if (num_vars_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_busy    <= 1'b1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= {thread_id_i,
                                          {VARIABLE_ADDRESS_WIDTH{1'b0}}};
                        end
                    end
                end
                S_ISSUE: begin
                    r_var_idx <= w_var_next;
                    if (w_is_last || w_word_end) begin
                        r_state     <= S_CAPTURE;
                        r_rd_en     <= 1'b0;
                        r_last_seen <= w_is_last;
                    end else begin
                        r_rd_addr <= {r_tid, w_var_next};
                    end
                end
                S_CAPTURE: begin
                    r_state   <= S_OUT;
                    r_m_valid <= 1'b1;
                    r_m_last  <= r_last_seen;
                end
                S_OUT: begin
                    if (w_handoff) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (r_m_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= {r_tid, r_var_idx};
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    variable_table_readout_bit_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_clear (w_handoff || w_start),
        .i_shift (r_cap),
        .i_bit   (rd_data_i),
        .o_word  (w_word)
    );

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign rd_en_o   = r_rd_en;
    assign rd_addr_o = r_rd_addr;
    assign m_data_o  = w_word;
    assign m_valid_o = r_m_valid;
    assign m_last_o  = r_m_last;

endmodule

// File: tb/tb_variable_table_readout.sv
// Directed bench for variable_table_readout with a behavioural table
// model, word/address monitors and hand-computed expected words.
module tb_variable_table_readout;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  thread_id_i = '0;
    logic [11:0] num_vars_i = '0;
    logic        busy_o, done_o, rd_en_o;
    logic [14:0] rd_addr_o;
    logic        rd_data_i = 1'b0;
    logic [31:0] m_data_o;
    logic        m_valid_o, m_last_o;
    logic        m_ready_i = 1'b1;

    logic mem [0:32767];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cnt, busy_cnt, first_issue, start_cyc, done_cyc;
    logic [14:0] addr_q[$];
    logic [31:0] word_q[$];
    logic        last_q[$];

    variable_table_readout dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .thread_id_i (thread_id_i),
        .num_vars_i  (num_vars_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_last_o    (m_last_o),
        .m_ready_i   (m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rd_en_o) rd_data_i <= mem[rd_addr_o];
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (start_i && start_cyc < 0) start_cyc = cyc;
            if (rd_en_o) begin
                addr_q.push_back(rd_addr_o);
                if (first_issue < 0) first_issue = cyc;
            end
            if (m_valid_o && m_ready_i) begin
                word_q.push_back(m_data_o);
                last_q.push_back(m_last_o);
            end
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(int tid, int num, int j);
        logic [31:0] w = '0;
        for (int k = 0; k < 32; k++)
            if (j * 32 + k < num) w[k] = mem[tid * 2048 + j * 32 + k];
        return w;
    endfunction

    task automatic clear_mon();
        addr_q.delete();
        word_q.delete();
        last_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        first_issue = -1;
        start_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic pulse_start(input int tid, input int num);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        thread_id_i = 4'(tid);
        num_vars_i = 12'(num);
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int pulse_at);
        int i;
        for (i = 0; i < 6000 && done_cnt == 0; i++) begin
            if (i == pulse_at) begin
                start_i = 1'b1;
                thread_id_i = 4'd7;
                num_vars_i = 12'd5;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic check_stream(input string tag, input int tid,
                                input int num);
        int nw = (num + 31) / 32;
        int werr = 0;
        int aerr = 0;
        int nlast = 0;
        check({tag, "_naddr"}, addr_q.size(), num);
        check({tag, "_nword"}, word_q.size(), nw);
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] != 15'(tid * 2048 + i)) aerr++;
        for (int j = 0; j < word_q.size(); j++) begin
            if (word_q[j] !== exp_word(tid, num, j)) begin
                werr++;
                if (werr < 4)
                    $display("FAIL %s_word%0d: got 0x%0h expected 0x%0h",
                             tag, j, word_q[j], exp_word(tid, num, j));
            end
            if (last_q[j]) nlast++;
        end
        check({tag, "_addr_seq"}, aerr, 0);
        check({tag, "_word_err"}, werr, 0);
        check({tag, "_nlast"}, nlast, 1);
        if (last_q.size() > 0)
            check({tag, "_last_pos"}, last_q[last_q.size() - 1], 1);
        check({tag, "_done"}, done_cnt, 1);
    endtask

    initial begin
        logic [31:0] pat;
        int stable_err;
        int rd_stall;
        logic [31:0] held;
        int i;

        for (int a = 0; a < 32768; a++) mem[a] = 1'b0;
        pat = 32'hA5A5_3C3C;
        for (int k = 0; k < 32; k++) mem[2 * 2048 + k] = pat[k];
        for (int k = 32; k < 64; k++) mem[3 * 2048 + k] = 1'b1;
        for (int k = 0; k < 64; k++) mem[4 * 2048 + k] = 1'($urandom);
        for (int k = 0; k < 64; k++) mem[5 * 2048 + k] = 1'($urandom);
        for (int k = 0; k < 2048; k++) mem[15 * 2048 + k] = 1'($urandom);
        clear_mon();

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_outs", {busy_o, done_o, rd_en_o, m_valid_o, m_last_o},
              0);
        check("rst_addr", rd_addr_o, 0);
        check("rst_data", m_data_o, 0);
        rst_i = 1'b0;

        // Full single word, ready held high throughout.
        clear_mon();
        pulse_start(2, 32);
        check("t1_busy", busy_o, 1);
        wait_done("t1", -1);
        check_stream("t1", 2, 32);
        check("t1_first", addr_q[0], 15'h1000);
        check("t1_lastaddr", addr_q[31], 15'h101F);
        check("t1_word", word_q[0], 32'hA5A5_3C3C);
        check("t1_latency", done_cyc - first_issue, 34);
        check("t1_busy_end", busy_o, 0);

        // Partial second word with ones beyond num in the table.
        clear_mon();
        pulse_start(3, 40);
        wait_done("t2", -1);
        check_stream("t2", 3, 40);
        check("t2_w0", word_q[0], 32'h0);
        check("t2_w1", word_q[1], 32'hFF);
        check("t2_l0", last_q[0], 0);

        // Empty command.
        clear_mon();
        pulse_start(2, 0);
        wait_done("t3", -1);
        check("t3_latency", done_cyc - start_cyc, 1);
        check("t3_naddr", addr_q.size(), 0);
        check("t3_nword", word_q.size(), 0);
        check("t3_busy", busy_cnt, 0);

        // Backpressure on the first word.
        clear_mon();
        m_ready_i = 1'b0;
        pulse_start(4, 33);
        for (i = 0; i < 200 && !m_valid_o; i++) begin
            @(posedge clk_i); #1;
        end
        check("t4_valid", m_valid_o, 1);
        held = m_data_o;
        check("t4_held", held, exp_word(4, 33, 0));
        stable_err = 0;
        rd_stall = 0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk_i);
            if (m_data_o !== held || !m_valid_o) stable_err++;
            if (rd_en_o) rd_stall++;
        end
        check("t4_stable", stable_err, 0);
        check("t4_rd_stall", rd_stall, 0);
        @(posedge clk_i); #1;
        m_ready_i = 1'b1;
        wait_done("t4", -1);
        check_stream("t4", 4, 33);
        check("t4_w1", word_q[1], {31'b0, mem[4 * 2048 + 32]});

        // Start pulsed while busy must not disturb the command.
        clear_mon();
        pulse_start(5, 40);
        wait_done("t5", 8);
        check_stream("t5", 5, 40);

        // Asynchronous reset in the middle of issuing.
        clear_mon();
        pulse_start(2, 32);
        repeat (5) @(posedge clk_i);
        #3;
        check("t6_pre_rd", rd_en_o, 1);
        rst_i = 1'b1;
        #1;
        check("t6_rst_outs",
              {busy_o, done_o, rd_en_o, m_valid_o, m_last_o}, 0);
        check("t6_rst_addr", rd_addr_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("t6_no_done", done_cnt, 0);
        clear_mon();
        pulse_start(2, 32);
        wait_done("t6", -1);
        check_stream("t6", 2, 32);
        check("t6_first", addr_q[0], 15'h1000);

        // Largest region, highest thread id.
        clear_mon();
        pulse_start(15, 2048);
        wait_done("t7", -1);
        check_stream("t7", 15, 2048);
        check("t7_lastaddr", addr_q[addr_q.size() - 1], 15'h7FFF);
        check("t7_l62", last_q[62], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
